// File: rtl/bit_drain_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bit_drain_sequencer_pkg
// Description : Shared drain-order encodings and FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package bit_drain_sequencer_pkg;

    // Same encodings as the first-set-bit selector
    localparam int FF_LEFT_TO_RIGHT = 0;
    localparam int FF_RIGHT_TO_LEFT = 1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } drain_state_t;

endpackage
`default_nettype wire

// File: rtl/find_first.sv
`default_nettype none
// ============================================================================
// Module      : find_first
// Description : One-hot select of the first set bit in the configured order.
// Revision    : 1.0 - initial release
// ============================================================================
module find_first
    import bit_drain_sequencer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int OPERATION = FF_LEFT_TO_RIGHT
) (
    input  logic [WIDTH-1:0] vec,
    output logic [WIDTH-1:0] onehot
);

    generate
        if (OPERATION == FF_RIGHT_TO_LEFT) begin : g_lsb_first
            logic w_seen;
            always_comb begin
                w_seen = 1'b0;
                onehot = '0;
                for (int i = 0; i < WIDTH; i++) begin
                    onehot[i] = vec[i] & ~w_seen;
                    w_seen    = w_seen | vec[i];
                end
            end
        end else begin : g_msb_first
            logic w_seen;
            always_comb begin
                w_seen = 1'b0;
                onehot = '0;
                for (int i = WIDTH - 1; i >= 0; i--) begin
                    onehot[i] = vec[i] & ~w_seen;
                    w_seen    = w_seen | vec[i];
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/onehot_to_index.sv
`default_nettype none
// ============================================================================
// Module      : onehot_to_index
// Description : One-hot to binary encoder, one OR-tree per index bit.
// Revision    : 1.0 - initial release
// ============================================================================
module onehot_to_index #(
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] onehot,
    output logic [IDX_W-1:0] index
);

    generate
        for (genvar b = 0; b < IDX_W; b++) begin : g_bit
            logic w_or;
            always_comb begin
                w_or = 1'b0;
                for (int i = 0; i < WIDTH; i++) begin
                    if (((i >> b) & 1) == 1) begin
                        w_or = w_or | onehot[i];
                    end
                end
            end
            assign index[b] = w_or;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/bit_drain_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : bit_drain_sequencer
// Description : Drains a bit-vector one set bit per beat in priority order.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_drain_sequencer
    import bit_drain_sequencer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int OPERATION = FF_LEFT_TO_RIGHT,
    parameter int IDX_W     = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_onehot,
    output logic [IDX_W-1:0] out_index,
    output logic             out_last,
    output logic [IDX_W:0]   out_count
);

    drain_state_t     r_state;
    logic [WIDTH-1:0] r_rem;
    logic [IDX_W:0]   r_cnt;

    logic [WIDTH-1:0] w_first;
    logic [WIDTH-1:0] w_onehot;
    logic             w_valid;
    logic             w_last;
    logic             w_fire;
    logic             w_accept;

    find_first #(
        .WIDTH     (WIDTH),
        .OPERATION (OPERATION)
    ) u_find_first (
        .vec    (r_rem),
        .onehot (w_first)
    );

    assign w_valid  = (r_state == ST_DRAIN);
    assign w_onehot = w_valid ? w_first : '0;
    assign w_last   = w_valid & ~|(r_rem & ~w_onehot);
    assign w_fire   = w_valid & out_ready;

    // out_ready -> in_ready is a deliberate combinational path for zero-gap reloads
    assign in_ready = ~flush & (~w_valid | (w_last & out_ready));
    assign w_accept = in_valid & in_ready;

    onehot_to_index #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_onehot_to_index (
        .onehot (w_onehot),
        .index  (out_index)
    );

    assign out_valid  = w_valid;
    assign out_onehot = w_onehot;
    assign out_last   = w_last;
    assign out_count  = w_valid ? r_cnt : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_rem   <= '0;
            r_cnt   <= '0;
        end else if (flush) begin
            r_state <= ST_IDLE;
            r_rem   <= '0;
            r_cnt   <= '0;
        end else begin
            if (w_fire) begin
                r_rem <= r_rem & ~w_onehot;
                r_cnt <= r_cnt + {{IDX_W{1'b0}}, 1'b1};
                if (w_last) begin
                    r_state <= ST_IDLE;
                end
            end
            // A zero vector is consumed without producing a beat
            if (w_accept) begin
                r_rem   <= in_vec;
                r_cnt   <= '0;
                r_state <= (in_vec != '0) ? ST_DRAIN : ST_IDLE;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bit_drain_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bit_drain_sequencer
// Description : Scoreboard bench driving an MSB-first and an LSB-first instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bit_drain_sequencer;

    typedef struct packed {
        logic [7:0] onehot;
        logic [2:0] index;
        logic       last;
        logic [3:0] count;
    } beat_t;

    logic       clk;
    logic       reset_n;
    logic       flush;
    logic       in_valid;
    logic [7:0] in_vec;
    logic       out_ready;

    logic       m_in_ready, m_out_valid, m_out_last;
    logic [7:0] m_out_onehot;
    logic [2:0] m_out_index;
    logic [3:0] m_out_count;
    logic       l_in_ready, l_out_valid, l_out_last;
    logic [7:0] l_out_onehot;
    logic [2:0] l_out_index;
    logic [3:0] l_out_count;

    beat_t q_msb[$];
    beat_t q_lsb[$];
    int    vectors    = 0;
    int    miscompares = 0;

    bit_drain_sequencer #(.WIDTH(8), .OPERATION(0)) dut_m (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (m_in_ready),
        .in_vec     (in_vec),
        .out_valid  (m_out_valid),
        .out_ready  (out_ready),
        .out_onehot (m_out_onehot),
        .out_index  (m_out_index),
        .out_last   (m_out_last),
        .out_count  (m_out_count)
    );

    bit_drain_sequencer #(.WIDTH(8), .OPERATION(1)) dut_l (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (l_in_ready),
        .in_vec     (in_vec),
        .out_valid  (l_out_valid),
        .out_ready  (out_ready),
        .out_onehot (l_out_onehot),
        .out_index  (l_out_index),
        .out_last   (l_out_last),
        .out_count  (l_out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: expected beat list in both orders; only the first 'keep' beats are queued
    task automatic push_expected(input logic [7:0] vec, input int keep);
        int    n;
        int    total;
        beat_t b;
        total = $countones(vec);
        n = 0;
        for (int i = 7; i >= 0; i--) begin
            if (vec[i]) begin
                b.onehot = 8'h01 << i;
                b.index  = i[2:0];
                b.count  = n[3:0];
                b.last   = (n == total - 1);
                if (n < keep) q_msb.push_back(b);
                n++;
            end
        end
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (vec[i]) begin
                b.onehot = 8'h01 << i;
                b.index  = i[2:0];
                b.count  = n[3:0];
                b.last   = (n == total - 1);
                if (n < keep) q_lsb.push_back(b);
                n++;
            end
        end
    endtask

    always @(negedge clk) begin
        if (reset_n === 1'b1 && flush === 1'b0 && m_out_valid === 1'b1 && out_ready === 1'b1) begin
            beat_t exp_b;
            vectors++;
            if (q_msb.size() == 0) begin
                miscompares++;
                $display("FAIL msb_beat: unexpected beat idx=%0d, expected none", m_out_index);
            end else begin
                exp_b = q_msb.pop_front();
                if ({m_out_onehot, m_out_index, m_out_last, m_out_count} !== exp_b) begin
                    miscompares++;
                    $display("FAIL msb_beat: got oh=%h idx=%0d last=%0b cnt=%0d, expected oh=%h idx=%0d last=%0b cnt=%0d",
                             m_out_onehot, m_out_index, m_out_last, m_out_count,
                             exp_b.onehot, exp_b.index, exp_b.last, exp_b.count);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n === 1'b1 && flush === 1'b0 && l_out_valid === 1'b1 && out_ready === 1'b1) begin
            beat_t exp_b;
            vectors++;
            if (q_lsb.size() == 0) begin
                miscompares++;
                $display("FAIL lsb_beat: unexpected beat idx=%0d, expected none", l_out_index);
            end else begin
                exp_b = q_lsb.pop_front();
                if ({l_out_onehot, l_out_index, l_out_last, l_out_count} !== exp_b) begin
                    miscompares++;
                    $display("FAIL lsb_beat: got oh=%h idx=%0d last=%0b cnt=%0d, expected oh=%h idx=%0d last=%0b cnt=%0d",
                             l_out_onehot, l_out_index, l_out_last, l_out_count,
                             exp_b.onehot, exp_b.index, exp_b.last, exp_b.count);
                end
            end
        end
    end

    // Drivers start and end at posedge+1
    task automatic drive_vec(input logic [7:0] vec, input int keep);
        push_expected(vec, keep);
        in_valid = 1'b1;
        in_vec   = vec;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_vec   = 8'h00;
    endtask

    task automatic wait_drained(input int budget, output int beats);
        bit done;
        done  = 1'b0;
        beats = 0;
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge clk);
            if (m_out_valid) beats++;
            if (!m_out_valid && !l_out_valid && q_msb.size() == 0 && q_lsb.size() == 0) done = 1'b1;
            @(posedge clk); #1;
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: got %0d/%0d beats left, expected 0/0", q_msb.size(), q_lsb.size());
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if ({m_out_valid, m_out_onehot, m_out_index, m_out_last, m_out_count, m_in_ready} !== {1'b0, 8'h00, 3'd0, 1'b0, 4'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_msb: got v=%0b oh=%h idx=%0d last=%0b cnt=%0d rdy=%0b, expected 0 00 0 0 0 1",
                     m_out_valid, m_out_onehot, m_out_index, m_out_last, m_out_count, m_in_ready);
        end
        vectors++;
        if ({l_out_valid, l_out_onehot, l_in_ready} !== {1'b0, 8'h00, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_lsb: got v=%0b oh=%h rdy=%0b, expected 0 00 1", l_out_valid, l_out_onehot, l_in_ready);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_order;
        int beats;
        out_ready = 1'b1;
        drive_vec(8'hA2, 99);
        vectors++;
        if ({m_out_valid, m_out_index, l_out_valid, l_out_index} !== {1'b1, 3'd7, 1'b1, 3'd1}) begin
            miscompares++;
            $display("FAIL order_latency: got mv=%0b midx=%0d lv=%0b lidx=%0d, expected 1 7 1 1",
                     m_out_valid, m_out_index, l_out_valid, l_out_index);
        end
        wait_drained(10, beats);
        vectors++;
        if (beats !== 3) begin
            miscompares++;
            $display("FAIL order_beats: got %0d, expected 3", beats);
        end
    endtask

    task automatic test_stall;
        logic [16:0] snap, snap_now;
        bit          prev_stall, done;
        int          fired;
        prev_stall = 1'b0;
        done       = 1'b0;
        fired      = 0;
        snap       = '0;
        drive_vec(8'hFF, 99);
        for (int c = 0; c < 40 && !done; c++) begin
            out_ready = ((c % 4) == 0) || ((c % 4) == 3);
            @(negedge clk);
            snap_now = {m_out_valid, m_out_onehot, m_out_index, m_out_last, m_out_count};
            if (prev_stall) begin
                vectors++;
                if (snap_now !== snap) begin
                    miscompares++;
                    $display("FAIL stall_hold: got %h, expected %h", snap_now, snap);
                end
            end
            if (m_out_valid && out_ready) fired++;
            snap       = snap_now;
            prev_stall = m_out_valid && !out_ready;
            if (!m_out_valid && q_msb.size() == 0 && q_lsb.size() == 0) done = 1'b1;
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        vectors++;
        if (!done || fired !== 8) begin
            miscompares++;
            $display("FAIL stall_beats: got %0d beats done=%0b, expected 8 done=1", fired, done);
        end
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1;
        push_expected(8'h01, 99);
        in_valid = 1'b1;
        in_vec   = 8'h01;
        @(negedge clk);
        vectors++;
        if (m_in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_idle_ready: got %0b, expected 1", m_in_ready);
        end
        @(posedge clk); #1;
        push_expected(8'h81, 99);
        in_vec = 8'h81;
        @(negedge clk);
        vectors++;
        if ({m_out_valid, m_in_ready, l_in_ready} !== 3'b111) begin
            miscompares++;
            $display("FAIL b2b_first_last: got v/rdy/lrdy=%b, expected 111", {m_out_valid, m_in_ready, l_in_ready});
        end
        @(posedge clk); #1;
        @(negedge clk);
        vectors++;
        if ({m_out_valid, m_in_ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL b2b_mid: got v/rdy=%b, expected 10", {m_out_valid, m_in_ready});
        end
        @(posedge clk); #1;
        in_vec = 8'h00;
        @(negedge clk);
        vectors++;
        if ({m_out_valid, m_in_ready} !== 2'b11) begin
            miscompares++;
            $display("FAIL b2b_second_last: got v/rdy=%b, expected 11", {m_out_valid, m_in_ready});
        end
        @(posedge clk); #1;
        @(negedge clk);
        vectors++;
        if ({m_out_valid, m_in_ready, l_out_valid} !== 3'b010) begin
            miscompares++;
            $display("FAIL b2b_zero_vec: got v/rdy/lv=%b, expected 010", {m_out_valid, m_in_ready, l_out_valid});
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if ({m_out_valid, m_in_ready} !== 2'b01 || q_msb.size() != 0 || q_lsb.size() != 0) begin
            miscompares++;
            $display("FAIL b2b_done: got v/rdy=%b left=%0d/%0d, expected 01 0/0",
                     {m_out_valid, m_in_ready}, q_msb.size(), q_lsb.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single_bit;
        int beats;
        out_ready = 1'b1;
        drive_vec(8'h80, 99);
        wait_drained(5, beats);
        vectors++;
        if (beats !== 1) begin
            miscompares++;
            $display("FAIL single_80: got %0d beats, expected 1", beats);
        end
        drive_vec(8'h01, 99);
        wait_drained(5, beats);
        vectors++;
        if (beats !== 1) begin
            miscompares++;
            $display("FAIL single_01: got %0d beats, expected 1", beats);
        end
    endtask

    task automatic test_flush;
        int beats;
        out_ready = 1'b1;
        drive_vec(8'hF0, 1);
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        vectors++;
        if (m_in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_ready: got %0b, expected 0", m_in_ready);
        end
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        vectors++;
        if ({m_out_valid, m_out_onehot, m_in_ready, l_out_valid} !== {1'b0, 8'h00, 1'b1, 1'b0} || dut_m.r_rem !== 8'h00) begin
            miscompares++;
            $display("FAIL flush_idle: got v=%0b oh=%h rdy=%0b lv=%0b rem=%h, expected 0 00 1 0 00",
                     m_out_valid, m_out_onehot, m_in_ready, l_out_valid, dut_m.r_rem);
        end
        @(posedge clk); #1;
        wait_drained(5, beats);
        vectors++;
        if (beats !== 0) begin
            miscompares++;
            $display("FAIL flush_no_beats: got %0d, expected 0", beats);
        end
    endtask

    task automatic test_async_reset;
        int beats;
        out_ready = 1'b1;
        drive_vec(8'hF0, 1);
        @(posedge clk); #1;
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({m_out_valid, m_out_onehot, m_out_index, m_out_last, m_out_count, m_in_ready} !== {1'b0, 8'h00, 3'd0, 1'b0, 4'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL async_reset: got v=%0b oh=%h idx=%0d last=%0b cnt=%0d rdy=%0b, expected 0 00 0 0 0 1",
                     m_out_valid, m_out_onehot, m_out_index, m_out_last, m_out_count, m_in_ready);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
        drive_vec(8'h5A, 99);
        wait_drained(10, beats);
        vectors++;
        if (beats !== 4) begin
            miscompares++;
            $display("FAIL post_reset_beats: got %0d, expected 4", beats);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_vec    = 8'h00;
        out_ready = 1'b1;
        test_reset();
        test_order();
        test_stall();
        test_back_to_back();
        test_single_bit();
        test_flush();
        test_async_reset();
        vectors++;
        if (q_msb.size() != 0 || q_lsb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_empty: got %0d/%0d pending, expected 0/0", q_msb.size(), q_lsb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
